// File: rtl/pixel_write_buffer_pkg.sv
// Shared VGA framebuffer constants, FIFO entry layout and the write-buffer state encoding.
package pixel_write_buffer_pkg;

    localparam int VGA_H_RES  = 160;
    localparam int VGA_V_RES  = 120;
    localparam int VGA_PIXELS = VGA_H_RES * VGA_V_RES;
    localparam int COLOUR_W   = 12;
    localparam int ADDR_W     = 15;
    localparam int ENTRY_W    = ADDR_W + COLOUR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

endpackage

// File: rtl/pixel_write_buffer_fifo.sv
// Synchronous pixel queue holding {address, colour} entries; head is read combinationally.
module pixel_fifo
    import pixel_write_buffer_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign rdata = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/pixel_write_buffer.sv
// Queues plotted pixels as framebuffer writes and performs whole-screen clears after draining.
module pixel_write_buffer
    import pixel_write_buffer_pkg::*;
#(
    parameter int H_RES      = VGA_H_RES,
    parameter int V_RES      = VGA_V_RES,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                iClock,
    input  logic                iResetn,
    input  logic [7:0]          iX,
    input  logic [7:0]          iY,
    input  logic [COLOUR_W-1:0] iColour,
    input  logic                iPlot,
    output logic                oReady,
    input  logic                iClear,
    input  logic [COLOUR_W-1:0] iClearColour,
    output logic [ADDR_W-1:0]   oMemAddr,
    output logic [COLOUR_W-1:0] oMemData,
    output logic                oMemWe,
    input  logic                iMemReady,
    output logic                oBusy,
    output logic                oDone,
    output logic [7:0]          oDropCount
);

    localparam int PIXELS = H_RES * V_RES;

    state_t                state;
    logic [ADDR_W-1:0]     clr_cnt;
    logic [COLOUR_W-1:0]   clear_colour;
    logic                  done;
    logic [7:0]            drop_cnt;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [ENTRY_W-1:0]    fifo_rdata;
    logic                  accept;
    logic                  in_range;

    // y*H_RES built from constant shifts of y, one term per set bit of H_RES.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] x, input logic [7:0] y);
        logic [ADDR_W-1:0] acc;
        acc = ADDR_W'(x);
        for (int i = 0; i < ADDR_W; i++) begin
            if (H_RES[i])
                acc = acc + (ADDR_W'(y) << i);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign oReady    = !fifo_full && (state == ST_IDLE);
    assign accept    = iPlot && oReady;
    assign in_range  = ({8'd0, iX} < 16'(H_RES)) && ({8'd0, iY} < 16'(V_RES));
    assign fifo_push = accept && in_range;
    assign fifo_pop  = (state != ST_CLEAR) && !fifo_empty && iMemReady;

    pixel_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (iClock),
        .rstn  (iResetn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({pix_addr(iX, iY), iColour}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        oMemWe   = !fifo_empty;
        oMemAddr = fifo_rdata[ENTRY_W-1:COLOUR_W];
        oMemData = fifo_rdata[COLOUR_W-1:0];
        if (state == ST_CLEAR) begin
            oMemWe   = 1'b1;
            oMemAddr = clr_cnt;
            oMemData = clear_colour;
        end
    end

    assign oBusy      = (state != ST_IDLE);
    assign oDone      = done;
    assign oDropCount = drop_cnt;

    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            state    <= ST_IDLE;
            clr_cnt  <= '0;
            done     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (accept && !in_range)
                drop_cnt <= sat_inc(drop_cnt);
            case (state)
                ST_IDLE: begin
                    if (iClear)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (fifo_empty)
                        state <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    if (iMemReady) begin
                        if (clr_cnt == ADDR_W'(PIXELS - 1)) begin
                            clr_cnt <= '0;
                            state   <= ST_IDLE;
                            done    <= 1'b1;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iClock) begin
        if (state == ST_IDLE && iClear)
            clear_colour <= iClearColour;
    end

endmodule
